// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - two-producer writeback staging FIFO feeding the register file write port
// Optional forwarding lookup built when WBQ_FORWARD_EN is defined.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          a_valid,
  input  logic [4:0]    a_rd,
  input  logic [31:0]   a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [4:0]    b_rd,
  input  logic [31:0]   b_data,
  output logic          b_ready,
  output logic          wr_en,
  output logic [4:0]    wr_rd,
  output logic [31:0]   wr_data,
  input  logic [4:0]    lookup_rd,
  output logic          fwd_hit,
  output logic [31:0]   fwd_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    rd_q   [DEPTH];
  logic [4:0]    rd_d   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];

  logic [CW-1:0] free;
  logic          need_b;
  logic          deq;
  logic          push_a;
  logic          push_b;
  logic [PW-1:0] a_slot;

  // Free slots count the head entry that drains this same cycle.
  always_comb begin
    free    = CW'(DEPTH) - count_q + CW'(count_q != '0);
    need_b  = b_valid && (b_rd != 5'd0);
    b_ready = !clr && (free >= CW'(1));
    a_ready = !clr && (free >= (need_b ? CW'(2) : CW'(1)));
    deq     = !clr && (count_q != '0);
    push_b  = need_b && b_ready;
    push_a  = a_valid && a_ready && (a_rd != 5'd0);
    a_slot  = tail_q + PW'(push_b);
  end

  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(push_b) + PW'(push_a);
    count_d = count_q - CW'(deq) + CW'(push_b) + CW'(push_a);
    if (push_b) begin
      rd_d[tail_q]   = b_rd;
      data_d[tail_q] = b_data;
    end
    if (push_a) begin
      rd_d[a_slot]   = a_rd;
      data_d[a_slot] = a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // Suppressed during clr so a discarded head never reaches the register file.
  assign wr_en   = deq;
  assign wr_rd   = wr_en ? rd_q[head_q] : 5'd0;
  assign wr_data = wr_en ? data_q[head_q] : 32'd0;
  assign count   = count_q;

`ifdef WBQ_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Oldest-to-youngest scan; later matches overwrite so the youngest wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    fwd_idx  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (lookup_rd != 5'd0) && (rd_q[fwd_idx] == lookup_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_rd;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - directed self-checking bench for wb_write_queue
module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          clr;
  logic          a_valid, b_valid;
  logic [4:0]    a_rd, b_rd, lookup_rd;
  logic [31:0]   a_data, b_data;
  logic          a_ready, b_ready, wr_en, fwd_hit;
  logic [4:0]    wr_rd;
  logic [31:0]   wr_data, fwd_data;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  wb_write_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .clr(clr),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .lookup_rd(lookup_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_fwd(input string tag, input logic [4:0] rd, input logic hit, input logic [31:0] data);
    lookup_rd = rd;
    #1;
`ifdef WBQ_FORWARD_EN
    check({tag, "_hit"}, 32'(fwd_hit), 32'(hit));
    check({tag, "_data"}, fwd_data, data);
`else
    check({tag, "_hit"}, 32'(fwd_hit), 32'd0);
    check({tag, "_data"}, fwd_data, 32'd0);
`endif
  endtask

  logic [4:0]  drain_rd   [4] = '{5'd2, 5'd12, 5'd3, 5'd13};
  logic [31:0] drain_data [4] = '{32'h102, 32'h201, 32'h103, 32'h202};

  initial begin
    clr = 1'b1;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    lookup_rd = '0;

    // reset / idle
    repeat (3) tick;
    check("rst_count", 32'(count), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    clr = 1'b0;
    #1;
    check("idle_a_ready", 32'(a_ready), 32'd1);
    check("idle_b_ready", 32'(b_ready), 32'd1);
    check("idle_wr_en", 32'(wr_en), 32'd0);
    check("idle_wr_data", wr_data, 32'd0);
    check_fwd("idle_fwd", 5'd5, 1'b0, 32'd0);

    // single push
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check("single_a_ready", 32'(a_ready), 32'd1);
    tick;
    a_valid = 1'b0;
    #1;
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_rd", 32'(wr_rd), 32'd5);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    check("single_count", 32'(count), 32'd1);
    check_fwd("single_fwd", 5'd5, 1'b1, 32'hDEADBEEF);
    check_fwd("single_miss", 5'd9, 1'b0, 32'd0);
    tick;
    check("single_count_after", 32'(count), 32'd0);
    check("single_wr_en_after", 32'(wr_en), 32'd0);
    check("single_wr_rd_after", 32'(wr_rd), 32'd0);

    // dual push to the same rd: B then A
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h1;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h2;
    #1;
    check("dual_a_ready", 32'(a_ready), 32'd1);
    tick;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("dual_count", 32'(count), 32'd2);
    check("dual_wr0_rd", 32'(wr_rd), 32'd7);
    check("dual_wr0_data", wr_data, 32'h1);
    check_fwd("dual_fwd0", 5'd7, 1'b1, 32'h2);
    tick;
    check("dual_wr1_en", 32'(wr_en), 32'd1);
    check("dual_wr1_data", wr_data, 32'h2);
    check_fwd("dual_fwd1", 5'd7, 1'b1, 32'h2);
    tick;
    check("dual_count_end", 32'(count), 32'd0);

    // fill to DEPTH with three dual pushes
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_rd = 5'(i + 1);  b_data = 32'h101 + 32'(i);
      a_valid = 1'b1; a_rd = 5'(i + 11); a_data = 32'h200 + 32'(i);
      tick;
    end
    b_rd = 5'd4; a_rd = 5'd14;
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_a_ready", 32'(a_ready), 32'd0);
    check("full_b_ready", 32'(b_ready), 32'd1);
    check_fwd("full_fwd", 5'd12, 1'b1, 32'h201);
    b_valid = 1'b0;
    #1;
    check("full_a_only_ready", 32'(a_ready), 32'd1);
    b_valid = 1'b1; b_rd = 5'd0;
    #1;
    check("full_b_null_a_ready", 32'(a_ready), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_wr_en", 32'(wr_en), 32'd1);
      check("drain_wr_rd", 32'(wr_rd), 32'(drain_rd[k]));
      check("drain_wr_data", wr_data, drain_data[k]);
      tick;
    end
    check("drain_empty_en", 32'(wr_en), 32'd0);
    check("drain_empty_count", 32'(count), 32'd0);

    // null push
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFFFFFF;
    #1;
    check("null_a_ready", 32'(a_ready), 32'd1);
    tick;
    a_valid = 1'b0;
    #1;
    check("null_count", 32'(count), 32'd0);
    check("null_wr_en", 32'(wr_en), 32'd0);
    check_fwd("null_fwd", 5'd0, 1'b0, 32'd0);

    // reset mid-operation with count = 3
    b_valid = 1'b1; b_rd = 5'd20; b_data = 32'h300;
    a_valid = 1'b1; a_rd = 5'd21; a_data = 32'h301;
    tick;
    b_rd = 5'd22; b_data = 32'h302;
    a_rd = 5'd23; a_data = 32'h303;
    tick;
    b_valid = 1'b0; a_valid = 1'b0;
    #1;
    check("mid_count_pre", 32'(count), 32'd3);
    clr = 1'b1;
    a_valid = 1'b1; a_rd = 5'd24; a_data = 32'h304;
    #1;
    check("mid_clr_a_ready", 32'(a_ready), 32'd0);
    check("mid_clr_b_ready", 32'(b_ready), 32'd0);
    check("mid_clr_wr_en", 32'(wr_en), 32'd0);
    tick;
    clr = 1'b0; a_valid = 1'b0;
    #1;
    check("mid_count_post", 32'(count), 32'd0);
    check("mid_wr_en_post", 32'(wr_en), 32'd0);
    check("mid_wr_data_post", wr_data, 32'd0);
    check_fwd("mid_fwd", 5'd23, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("mid_never_written", 32'(wr_en), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
